// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI mode-0 frame receiver/transmitter, fully clocked on clk.
// sck/sdi/load are oversampled through synchronisers; a complete frame of
// FRAME_BITS bits is handed to the consumer through a valid/ready slot.
// Optional feature: define SPI_RX_MATCH_EN to add the registered `match`
// output comparing frame_data against MATCH_PATTERN.
module spi_frame_rx #(
    parameter int unsigned           FRAME_BITS    = 128,
    parameter int unsigned           SYNC_STAGES   = 2,
    parameter bit                    MSB_FIRST     = 1'b1,
    parameter logic [FRAME_BITS-1:0] MATCH_PATTERN = {FRAME_BITS/16{16'hFF00}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  load,
    output logic                  sdo,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  frame_err,
    output logic                  overflow,
    output logic                  busy
`ifdef SPI_RX_MATCH_EN
    ,
    output logic                  match
`endif
);

    // Counter must reach FRAME_BITS+1 (saturation marks an over-long frame).
    localparam int unsigned     CW       = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0]   CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0]   CNT_SAT  = CW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_CLOSE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, load_sync;
    logic                   sck_hist, sdi_hist, load_hist;
    logic                   sck_s, load_s;
    logic                   sck_rise, sck_fall, load_rise, load_fall;
    logic                   start;

    logic [CW-1:0]          count;
    logic [FRAME_BITS-1:0]  rx_shift;
    logic [FRAME_BITS-1:0]  tx_shift;

    // Synchroniser chains plus one history flop per input for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            sdi_sync  <= '0;
            load_sync <= '0;
            sck_hist  <= 1'b0;
            sdi_hist  <= 1'b0;
            load_hist <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            load_sync <= {load_sync[SYNC_STAGES-2:0], load};
            sck_hist  <= sck_sync[SYNC_STAGES-1];
            sdi_hist  <= sdi_sync[SYNC_STAGES-1];
            load_hist <= load_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign load_s    = load_sync[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_hist;
    assign sck_fall  = ~sck_s & sck_hist;
    assign load_rise = load_s & ~load_hist;
    assign load_fall = ~load_s & load_hist;

    // A rise seen in CLOSE restarts immediately so a one-sample load gap
    // still closes the previous frame before the next one begins.
    assign start = load_rise & (state != ST_ACTIVE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (load_rise) state_next = ST_ACTIVE;
            ST_ACTIVE: if (load_fall) state_next = ST_CLOSE;
            ST_CLOSE:  state_next = load_rise ? ST_ACTIVE : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_ACTIVE);

    // Receive/transmit shift registers and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            sdo      <= 1'b0;
        end else if (start) begin
            count    <= '0;
            rx_shift <= '0;
            tx_shift <= tx_data;
            sdo      <= MSB_FIRST ? tx_data[FRAME_BITS-1] : tx_data[0];
        end else if (state == ST_ACTIVE) begin
            if (sck_rise && (count != CNT_SAT)) begin
                count <= count + 1'b1;
                if (count != CNT_FULL) begin
                    rx_shift <= MSB_FIRST ? {rx_shift[FRAME_BITS-2:0], sdi_hist}
                                          : {sdi_hist, rx_shift[FRAME_BITS-1:1]};
                end
            end
            if (sck_fall) begin
                tx_shift <= MSB_FIRST ? (tx_shift << 1) : (tx_shift >> 1);
                sdo      <= MSB_FIRST ? tx_shift[FRAME_BITS-2] : tx_shift[1];
            end
        end else begin
            sdo <= 1'b0;
        end
    end

    // Frame hand-off: accept, drop with overflow, or flag a bad length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (state == ST_CLOSE) begin
                if (count == CNT_FULL) begin
                    if (!frame_valid || frame_ready) begin
                        frame_data  <= rx_shift;
                        frame_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_RX_MATCH_EN
    // Registered pattern compare, trails frame_data by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else begin
            match <= (frame_data == MATCH_PATTERN);
        end
    end
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Testbench for spi_frame_rx: a 128-bit MSB-first instance and a 16-bit
// LSB-first instance share sck/sdi; each has its own load line.
module tb_spi_frame_rx;

    localparam int unsigned FB   = 128;
    localparam int unsigned HALF = 6;
    localparam logic [127:0] PAT = {8{16'hFF00}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sck = 1'b0;
    logic sdi = 1'b0;
    logic load_a = 1'b0;
    logic load_b = 1'b0;
    logic [127:0] tx_a = '0;
    logic [15:0]  tx_b = '0;
    logic ready_a = 1'b0;
    logic ready_b = 1'b0;
    logic sdo_a, sdo_b;
    logic [127:0] data_a;
    logic [15:0]  data_b;
    logic valid_a, valid_b, err_a, err_b, ovf_a, ovf_b, busy_a, busy_b;
`ifdef SPI_RX_MATCH_EN
    logic match_a, match_b;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int err_cnt_a = 0, err_cnt_b = 0, vrise_a = 0, vrise_b = 0;
    logic va_q = 1'b0, vb_q = 1'b0;

    // reference model state for the 128-bit instance
    logic [127:0] exp_data = '0;
    bit exp_valid = 1'b0;
    bit exp_ovf = 1'b0;

    always #5 clk = ~clk;

    spi_frame_rx #(.FRAME_BITS(128), .SYNC_STAGES(2), .MSB_FIRST(1'b1), .MATCH_PATTERN(PAT)) dut_a (
        .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .load(load_a), .sdo(sdo_a),
        .tx_data(tx_a), .frame_data(data_a), .frame_valid(valid_a), .frame_ready(ready_a),
        .frame_err(err_a), .overflow(ovf_a), .busy(busy_a)
`ifdef SPI_RX_MATCH_EN
        , .match(match_a)
`endif
    );

    spi_frame_rx #(.FRAME_BITS(16), .SYNC_STAGES(3), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .load(load_b), .sdo(sdo_b),
        .tx_data(tx_b), .frame_data(data_b), .frame_valid(valid_b), .frame_ready(ready_b),
        .frame_err(err_b), .overflow(ovf_b), .busy(busy_b)
`ifdef SPI_RX_MATCH_EN
        , .match(match_b)
`endif
    );

    // event counters: error pulses and frame_valid rising edges
    always @(negedge clk) begin
        if (err_a) err_cnt_a++;
        if (err_b) err_cnt_b++;
        if (valid_a && !va_q) vrise_a++;
        if (valid_b && !vb_q) vrise_b++;
        va_q = valid_a;
        vb_q = valid_b;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [263:0] got, input logic [263:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // bit i of the result is the i-th bit on the wire when sending w MSB first
    function automatic logic [263:0] ser_msb(input logic [127:0] w);
        logic [263:0] s = '0;
        for (int unsigned i = 0; i < 128; i++) s[i] = w[127-i];
        return s;
    endfunction

    function automatic logic [263:0] rnd_bits();
        logic [263:0] s;
        for (int unsigned i = 0; i < 9; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    // what the MCU should capture from the 128-bit instance: tx MSB first, then zeros
    function automatic logic [263:0] mcu_exp(input logic [127:0] tx, input int unsigned n);
        logic [263:0] e = '0;
        for (int unsigned i = 0; i < n; i++) e[i] = (i < 128) ? tx[127-i] : 1'b0;
        return e;
    endfunction

    // MCU side of one frame: load high, n mode-0 bit periods, load low, then gap idle clks
    task automatic send_frame(input bit to16, input int unsigned n, input logic [263:0] s,
                              input int unsigned gap, output logic [263:0] got);
        got = '0;
        @(negedge clk);
        if (to16) load_b = 1'b1; else load_a = 1'b1;
        repeat (8) @(negedge clk);
        for (int unsigned i = 0; i < n; i++) begin
            sdi = s[i];
            repeat (HALF) @(negedge clk);
            got[i] = to16 ? sdo_b : sdo_a;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        if (to16) load_b = 1'b0; else load_a = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // model update for one completed frame on the 128-bit instance
    task automatic model_frame(input int unsigned n, input logic [263:0] s, input bit rdy,
                               output int exp_err, output int exp_rise);
        logic [127:0] word;
        exp_err = 0;
        exp_rise = 0;
        for (int unsigned i = 0; i < 128; i++) word[127-i] = s[i];
        if (n != FB) begin
            exp_err = 1;
        end else if (!exp_valid || rdy) begin
            exp_data = word;
            exp_rise = 1;
            exp_valid = !rdy;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_data"}, data_a, exp_data);
        check_eq({tag, "_valid"}, valid_a, exp_valid);
        check_eq({tag, "_ovf"}, ovf_a, exp_ovf);
        check_eq({tag, "_sdo_idle"}, sdo_a, 1'b0);
        check_eq({tag, "_busy"}, busy_a, 1'b0);
`ifdef SPI_RX_MATCH_EN
        check_eq({tag, "_match"}, match_a, exp_data == PAT);
`endif
    endtask

    task automatic do_frame128(input string tag, input int unsigned n, input logic [263:0] s,
                               input logic [127:0] tx, input bit rdy);
        logic [263:0] got;
        int e0, r0, xe, xr;
        tx_a = tx;
        ready_a = rdy;
        repeat (2) @(negedge clk);
        if (rdy) exp_valid = 1'b0;
        e0 = err_cnt_a;
        r0 = vrise_a;
        send_frame(1'b0, n, s, 14, got);
        model_frame(n, s, rdy, xe, xr);
        check_state(tag);
        check_eq({tag, "_errs"}, 264'(err_cnt_a - e0), 264'(xe));
        check_eq({tag, "_vrise"}, 264'(vrise_a - r0), 264'(xr));
        check_eq({tag, "_mcu"}, got, mcu_exp(tx, n));
    endtask

    initial begin
        logic [263:0] s, s2, got, got2;
        logic [127:0] wa, wb;
        int e0, r0, xe, xr;
        int unsigned lens [4] = '{127, 128, 128, 129};

        // reset state
        repeat (4) @(negedge clk);
        check_eq("rst_data", data_a, '0);
        check_eq("rst_valid", valid_a, 1'b0);
        check_eq("rst_err", err_a, 1'b0);
        check_eq("rst_ovf", ovf_a, 1'b0);
        check_eq("rst_busy", busy_a, 1'b0);
        check_eq("rst_sdo", sdo_a, 1'b0);
        check_eq("rst_data16", data_b, '0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // pattern frame with ready high, tx word checked on the MCU side
        do_frame128("pat", 128, ser_msb(PAT), 128'h0123456789ABCDEF0123456789ABCDEF, 1'b1);

        // short then long frames
        do_frame128("short", 127, rnd_bits(), {4{$urandom}}, 1'b1);
        do_frame128("long", 129, rnd_bits(), {4{$urandom}}, 1'b1);

        // consumer stalled: A kept, B dropped with overflow
        wa = {4{$urandom}};
        wb = {4{$urandom}};
        do_frame128("stallA", 128, ser_msb(wa), {4{$urandom}}, 1'b0);
        do_frame128("stallB", 128, ser_msb(wb), {4{$urandom}}, 1'b0);
        check_eq("stall_keepA", data_a, wa);
        ready_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_valid = 1'b0;
        check_eq("stall_release", valid_a, 1'b0);
        ready_a = 1'b0;

        // back-to-back frames with a one-clk load gap: both must close
        ready_a = 1'b1;
        repeat (2) @(negedge clk);
        e0 = err_cnt_a;
        r0 = vrise_a;
        wa = {4{$urandom}};
        wb = {4{$urandom}};
        tx_a = wa;
        s = rnd_bits();
        s2 = rnd_bits();
        send_frame(1'b0, 128, s, 0, got);
        tx_a = wb;
        send_frame(1'b0, 128, s2, 14, got2);
        model_frame(128, s, 1'b1, xe, xr);
        model_frame(128, s2, 1'b1, xe, xr);
        check_state("b2b");
        check_eq("b2b_vrise", 264'(vrise_a - r0), 264'd2);
        check_eq("b2b_errs", 264'(err_cnt_a - e0), 264'd0);
        check_eq("b2b_mcuA", got, mcu_exp(wa, 128));
        check_eq("b2b_mcuB", got2, mcu_exp(wb, 128));

        // randomized frames: length, data, tx word and ready policy
        for (int unsigned k = 0; k < 6; k++) begin
            do_frame128($sformatf("rnd%0d", k), lens[$urandom_range(0, 3)], rnd_bits(),
                        {4{$urandom}}, 1'($urandom_range(0, 1)));
        end

        // 16-bit LSB-first instance
        tx_b = 16'h3C5A;
        ready_b = 1'b1;
        r0 = vrise_b;
        s = '0;
        s[15:0] = 16'h8001;
        send_frame(1'b1, 16, s, 14, got);
        check_eq("lsb_data", data_b, 16'h8001);
        check_eq("lsb_vrise", 264'(vrise_b - r0), 264'd1);
        check_eq("lsb_mcu", got[15:0], tx_b);
        check_eq("lsb_sdo_idle", sdo_b, 1'b0);
        e0 = err_cnt_b;
        send_frame(1'b1, 15, rnd_bits(), 14, got);
        check_eq("lsb_short_err", 264'(err_cnt_b - e0), 264'd1);
        check_eq("lsb_short_keep", data_b, 16'h8001);
        check_eq("lsb_short_valid", valid_b, 1'b0);

        // force a sticky overflow so the reset below has something to clear
        ready_a = 1'b0;
        do_frame128("preA", 128, rnd_bits(), {4{$urandom}}, 1'b0);
        do_frame128("preB", 128, rnd_bits(), {4{$urandom}}, 1'b0);

        // reset in the middle of a frame
        @(negedge clk);
        load_a = 1'b1;
        repeat (8) @(negedge clk);
        for (int unsigned i = 0; i < 64; i++) begin
            sdi = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_eq("mid_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        load_a = 1'b0;
        @(negedge clk);
        exp_data = '0;
        exp_valid = 1'b0;
        exp_ovf = 1'b0;
        check_state("inrst");
        check_eq("inrst_data16", data_b, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        e0 = err_cnt_a;
        do_frame128("post_rst", 128, ser_msb({16{8'h5A}}), {4{$urandom}}, 1'b0);
        check_eq("post_rst_noerr", 264'(err_cnt_a - e0), 264'd0);
        check_eq("idle16_valid", valid_b, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 128: bits per frame, range 8..256.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on sck/sdi/load, range 2..3.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in frame_data[FRAME_BITS-1]; 0 = lands in bit 0.
REQ-004 SHALL have parameter MATCH_PATTERN, width FRAME_BITS, default {FRAME_BITS/16{16'hFF00}}: compare value for match.
REQ-005 clk  input  1  system clock; every flop runs on clk, none on sck.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 sck  input  1  SPI clock, mode 0, asynchronous to clk, at most clk/4.
REQ-008 sdi  input  1  serial data from MCU.
REQ-009 load  input  1  active-high frame enable; high for whole frame.
REQ-010 sdo  output  1  serial data to MCU.
REQ-011 tx_data  input  FRAME_BITS  word shifted out on sdo, sampled at frame start.
REQ-012 frame_data  output  FRAME_BITS  last accepted frame.
REQ-013 frame_valid  output  1  frame_data holds unconsumed frame.
REQ-014 frame_ready  input  1  consumer accepts frame when frame_valid & frame_ready.
REQ-015 frame_err  output  1  one-clk pulse: frame ended with bit count != FRAME_BITS.
REQ-016 overflow  output  1  sticky: good frame dropped because frame_valid still high.
REQ-017 busy  output  1  frame in progress (synchronised load high).
REQ-018 match  output  1  frame_data == MATCH_PATTERN (present only with SPI_RX_MATCH_EN).

Function
REQ-019 sck, sdi, load SHALL each pass through SYNC_STAGES flops, then one history flop for edge detection.
REQ-020 State machine IDLE -> ACTIVE on synchronised load rise; ACTIVE -> CLOSE on synchronised load fall; CLOSE -> IDLE after one clk.
REQ-021 On load rise: bit counter cleared to 0, shift register cleared, tx shift register loaded from tx_data, sdo driven with tx_data MSB (or LSB if MSB_FIRST=0).
REQ-022 In ACTIVE, each synchronised sck rise SHALL shift synchronised sdi into the shift register per MSB_FIRST and increment counter.
REQ-023 Counter SHALL saturate at FRAME_BITS+1; bits past FRAME_BITS are discarded, shift register unaffected.
REQ-024 In ACTIVE, each synchronised sck fall SHALL advance tx shift register and present next bit on sdo; after FRAME_BITS bits sdo = 0.
REQ-025 sck edges in IDLE/CLOSE SHALL be ignored; sdo = 0 in IDLE.
REQ-026 In CLOSE, count == FRAME_BITS and frame_valid low: frame_data <= shift register, frame_valid set on the next clk (latency SYNC_STAGES+2 clk from load fall at pin).
REQ-027 In CLOSE, count == FRAME_BITS and frame_valid high without same-cycle handshake: frame dropped, overflow set, frame_data unchanged.
REQ-028 In CLOSE, count != FRAME_BITS (short or long): frame_err pulses one clk, frame_data/frame_valid unchanged.
REQ-029 frame_valid SHALL clear on the clk after frame_valid & frame_ready; a handshake in the CLOSE cycle frees the slot and the new frame is accepted (no overflow).
REQ-030 overflow SHALL clear only on reset.
REQ-031 load falling then rising within one synchronised sample SHALL still pass through CLOSE for one clk before ACTIVE.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, counter 0, all synchronisers 0, sdo 0, frame_data 0, frame_valid 0, frame_err 0, overflow 0, busy 0, match 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release, a frame is accepted only after a fresh load rise.

Configuration
REQ-034 Macro SPI_RX_MATCH_EN defined: match port exists, registered compare of frame_data vs MATCH_PATTERN, valid one clk after frame_data updates.
REQ-035 Macro undefined: match port and comparator absent; all other behaviour identical.

Verification
REQ-036 FRAME_BITS=128, send 128'hFF00FF00FF00FF00FF00FF00FF00FF00 with frame_ready=1 -> frame_data equals it, frame_valid one-cycle pulse, match=1 (macro on).
REQ-037 Send 127 bits, then 129 bits -> frame_err pulses once each, frame_valid stays 0, frame_data unchanged.
REQ-038 frame_ready=0, send two good frames A then B -> frame_data=A, frame_valid=1, overflow=1; assert ready -> frame_valid falls.
REQ-039 tx_data=128'h0123...CDEF, full frame -> 128 bits captured on MCU side equal tx_data MSB first; sdo=0 afterwards.
REQ-040 MSB_FIRST=0, FRAME_BITS=16, send 16'h8001 serially -> frame_data=16'h8001 bit-reversed (16'h8001).
REQ-041 rst_n low after 64 bits, release, full frame 128'h5A.. -> only second frame reported, no frame_err.
